// File: rtl/t05_hist_drain_pkg.sv
// Package t05_pkg: shared definitions for the histogram drain block.
//   - wr_r_en encoding of the shared SRAM port (read / write / idle)
//   - drain FSM state type
package t05_pkg;

    localparam logic [1:0] WRR_RD   = 2'd0;
    localparam logic [1:0] WRR_WR   = 2'd1;
    localparam logic [1:0] WRR_IDLE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_EMIT,
        S_WR_REQ,
        S_NEXT,
        S_DONE
    } drain_state_t;

endpackage

// File: rtl/t05_hist_drain.sv
// t05_hist_drain: walks the byte histogram in SRAM after end-of-file and
// streams every non-zero bin as a (char, count) pair. It can optionally zero
// each bin after reading it. It also compares the sum of all counts against
// the builder's character total.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, clear_en,         begin a drain (IDLE only); clear_en and
//   expected_total           expected_total are sampled together with start
//   sram_addr, sram_wr_data, SRAM request (wr_r_en 0=read, 1=write, 3=idle)
//   sram_wr_r_en
//   sram_rd_data, sram_ack   SRAM response; rd_data valid while ack=1
//   out_valid/out_ready,     pair stream to the tree/sort stage
//   out_char, out_count
//   busy, done               drain in progress / one-cycle completion pulse
//   leaf_count, sum_mismatch results of the last drain, held until next start
module t05_hist_drain
    import t05_pkg::*;
#(
    parameter int unsigned NUM_BINS  = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SKIP_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear_en,
    input  logic [CNT_W-1:0]    expected_total,
    input  logic [CNT_W-1:0]    sram_rd_data,
    input  logic                sram_ack,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [CNT_W-1:0]    sram_wr_data,
    output logic [1:0]          sram_wr_r_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_char,
    output logic [CNT_W-1:0]    out_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     leaf_count,
    output logic                sum_mismatch
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

    drain_state_t        state, state_d;
    logic [ADDR_W-1:0]   addr;
    logic                clear_q;
    logic [CNT_W-1:0]    exp_q;
    logic [CNT_W-1:0]    sum;
    logic [ADDR_W:0]     leaf_cnt;
    logic                skip_bin;

    assign sram_addr    = addr;
    assign sram_wr_data = '0;
    assign skip_bin     = (sram_rd_data == '0) && (SKIP_ZERO != 0);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start) state_d = S_RD_REQ;
            S_RD_REQ: begin
                if (sram_ack) begin
                    if (skip_bin) state_d = clear_q ? S_WR_REQ : S_NEXT;
                    else          state_d = S_EMIT;
                end
            end
            S_EMIT:   if (out_ready) state_d = clear_q ? S_WR_REQ : S_NEXT;
            S_WR_REQ: if (sram_ack) state_d = S_NEXT;
            S_NEXT:   state_d = (addr == LAST_ADDR) ? S_DONE : S_RD_REQ;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs are registered by decoding the next state, so they change
    // on the same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr         <= '0;
            clear_q      <= 1'b0;
            exp_q        <= '0;
            sum          <= '0;
            leaf_cnt     <= '0;
            sram_wr_r_en <= WRR_IDLE;
            out_valid    <= 1'b0;
            out_char     <= '0;
            out_count    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            leaf_count   <= '0;
            sum_mismatch <= 1'b0;
        end else begin
            state     <= state_d;
            out_valid <= (state_d == S_EMIT);
            done      <= (state_d == S_DONE);
            busy      <= (state_d == S_RD_REQ) || (state_d == S_EMIT) ||
                         (state_d == S_WR_REQ) || (state_d == S_NEXT);
            case (state_d)
                S_RD_REQ: sram_wr_r_en <= WRR_RD;
                S_WR_REQ: sram_wr_r_en <= WRR_WR;
                default:  sram_wr_r_en <= WRR_IDLE;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        clear_q      <= clear_en;
                        exp_q        <= expected_total;
                        sum          <= '0;
                        leaf_cnt     <= '0;
                        leaf_count   <= '0;
                        sum_mismatch <= 1'b0;
                        addr         <= '0;
                    end
                end
                S_RD_REQ: begin
                    if (sram_ack) begin
                        out_count <= sram_rd_data;
                        out_char  <= addr;
                        if (!skip_bin) begin
                            sum <= sum + sram_rd_data;
                            if (sram_rd_data != '0)
                                leaf_cnt <= leaf_cnt + (ADDR_W+1)'(1);
                        end
                    end
                end
                S_NEXT: begin
                    // Results are latched on entry to DONE so they are
                    // already valid while done pulses.
                    if (addr == LAST_ADDR) begin
                        sum_mismatch <= (sum != exp_q);
                        leaf_count   <= leaf_cnt;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t05_hist_drain.sv
// Self-checking bench for t05_hist_drain: an SRAM stub with programmable ack
// delay, a histogram reference model, directed cases and randomized drains.
module tb_t05_hist_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear_en;
    logic [31:0] expected_total;
    logic [31:0] sram_rd_data;
    logic        sram_ack;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wr_data;
    logic [1:0]  sram_wr_r_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic [31:0] out_count;
    logic        busy;
    logic        done;
    logic [8:0]  leaf_count;
    logic        sum_mismatch;

    t05_hist_drain #(.NUM_BINS(256), .ADDR_W(8), .CNT_W(32), .SKIP_ZERO(1)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_en(clear_en),
        .expected_total(expected_total), .sram_rd_data(sram_rd_data),
        .sram_ack(sram_ack), .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
        .sram_wr_r_en(sram_wr_r_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_count(out_count), .busy(busy), .done(done),
        .leaf_count(leaf_count), .sum_mismatch(sum_mismatch)
    );

    always #5 clk = ~clk;

    // SRAM stub: ack once a request has been held for ack_delay cycles.
    logic [31:0] mem [256];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    assign sram_ack     = ((sram_wr_r_en == 2'd0) || (sram_wr_r_en == 2'd1)) && (wait_cnt >= ack_delay);
    assign sram_rd_data = mem[sram_addr];

    always @(posedge clk) begin
        if (sram_wr_r_en != 2'd3 && !sram_ack) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_wr_r_en", sram_wr_r_en, 3);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_out_char", out_char, 0);
        check_eq("rst_out_count", out_count, 0);
        check_eq("rst_leaf_count", leaf_count, 0);
        check_eq("rst_mismatch", sum_mismatch, 0);
        check_eq("rst_wr_data", sram_wr_data, 0);
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 256; b++) mem[b] = '0;
    endtask

    task automatic load_case2();
        clear_mem();
        mem[8'h1A] = 32'd1;
        mem[8'h61] = 32'd3;
        mem[8'h62] = 32'd1;
    endtask

    // One full drain checked against a model built from the current bins.
    task automatic run_drain(input logic clr, input logic [31:0] exp_tot,
                             input int stall_cycles, input bit rnd, input int exp_cycles);
        logic [7:0]  q_char[$];
        logic [31:0] q_cnt[$];
        logic [31:0] msum = 0;
        int          leaves = 0;
        int          c, npairs = 0, reads = 0, stall = 0;
        bit          seen_done = 0, first_req = 1, pend = 0, any_valid = 0;
        logic [1:0]  p_en = 2'd3;
        logic [7:0]  p_addr = '0, s_char = '0;
        logic [31:0] s_cnt = '0;

        for (int b = 0; b < 256; b++) begin
            if (mem[b] != 0) begin
                q_char.push_back(8'(b));
                q_cnt.push_back(mem[b]);
                msum = msum + mem[b];
                leaves++;
            end
        end

        @(negedge clk);
        clear_en = clr; expected_total = exp_tot; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("leaf_cleared_on_start", leaf_count, 0);
        check_eq("mismatch_cleared_on_start", sum_mismatch, 0);

        for (c = 1; c < 20000; c++) begin
            if (rnd && c == 3) start = 1'b1;
            if (rnd && c == 4) start = 1'b0;
            if (pend) begin
                check_eq("req_hold_en", sram_wr_r_en, p_en);
                check_eq("req_hold_addr", sram_addr, p_addr);
            end
            if (first_req && sram_wr_r_en == 2'd0) begin
                check_eq("first_rd_addr", sram_addr, 0);
                first_req = 0;
            end
            pend   = (sram_wr_r_en != 2'd3) && !sram_ack;
            p_en   = sram_wr_r_en;
            p_addr = sram_addr;
            if (sram_wr_r_en == 2'd0 && sram_ack) reads++;
            if (sram_wr_r_en == 2'd1 && sram_ack) begin
                check_eq("wr_data_zero", sram_wr_data, 0);
                mem[sram_addr] = '0;
            end
            if (out_valid) begin
                any_valid = 1;
                check_eq("emit_sram_idle", sram_wr_r_en, 3);
                if (npairs == 0 && stall < stall_cycles) begin
                    if (stall > 0) begin
                        check_eq("stall_char", out_char, s_char);
                        check_eq("stall_count", out_count, s_cnt);
                    end
                    s_char = out_char; s_cnt = out_count;
                    stall++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    if (npairs < q_char.size()) begin
                        check_eq("pair_char", out_char, q_char[npairs]);
                        check_eq("pair_count", out_count, q_cnt[npairs]);
                    end else begin
                        check_eq("pair_overflow", npairs, q_char.size());
                    end
                    npairs++;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(negedge clk);
        end

        out_ready = 1'b0;
        check_eq("done_seen", seen_done, 1);
        if (exp_cycles > 0) check_eq("done_cycle", c, exp_cycles);
        if (q_char.size() == 0) check_eq("no_valid", any_valid, 0);
        check_eq("pairs_emitted", npairs, q_char.size());
        check_eq("reads", reads, 256);
        check_eq("leaf_count", leaf_count, leaves);
        check_eq("sum_mismatch", sum_mismatch, (msum != exp_tot));
        check_eq("busy_at_done", busy, 0);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("leaf_hold", leaf_count, leaves);
        check_eq("mismatch_hold", sum_mismatch, (msum != exp_tot));
        if (clr) begin
            int nz = 0;
            for (int b = 0; b < 256; b++) if (mem[b] != 0) nz++;
            check_eq("bins_cleared", nz, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear_en = 1'b0; expected_total = '0; out_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // 1: all-zero histogram, immediate ack
        ack_delay = 0;
        run_drain(1'b0, 32'd0, 0, 0, 513);

        // 2: three leaves in ascending order
        load_case2();
        run_drain(1'b0, 32'd5, 0, 0, 0);

        // 3: consumer stalls the first pair
        run_drain(1'b0, 32'd5, 6, 0, 0);

        // 5: wrong expected total, then cleared by the next start
        run_drain(1'b0, 32'd6, 0, 0, 0);
        run_drain(1'b0, 32'd5, 0, 0, 0);

        // 4: clearing with slow SRAM, then a drain that emits nothing
        ack_delay = 3;
        run_drain(1'b1, 32'd5, 0, 0, 0);
        run_drain(1'b0, 32'd0, 0, 0, 0);
        ack_delay = 0;

        // 6: reset while 0x61 is being offered
        load_case2();
        @(negedge clk);
        clear_en = 1'b0; expected_total = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (out_valid && out_char == 8'h61) break;
            out_ready = out_valid;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("reached_0x61", {out_valid, out_char}, {1'b1, 8'h61});
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        run_drain(1'b0, 32'd5, 0, 0, 0);

        // randomized drains
        for (int it = 0; it < 6; it++) begin
            logic [31:0] s = 0;
            int          k = $urandom_range(0, 10);
            clear_mem();
            for (int j = 0; j < k; j++) begin
                int b = $urandom_range(0, 255);
                mem[b] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255))
                                                     : 32'($urandom_range(1, 1000));
            end
            for (int b = 0; b < 256; b++) s = s + mem[b];
            ack_delay = $urandom_range(0, 3);
            run_drain(1'($urandom_range(0, 1)), s + 32'($urandom_range(0, 1)), $urandom_range(0, 3), 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
